// File: rtl/hp1349a_pkg.sv
// Shared constants for the HP1349A display-word decoder: opcodes, command types,
// Set Condition field selectors, coordinate width and the decoder FSM encoding.
package hp1349a_pkg;

    localparam int COORD_W = 11;

    localparam logic [1:0] OP_PLOT    = 2'b00;
    localparam logic [1:0] OP_GRAPH   = 2'b01;
    localparam logic [1:0] OP_TEXT    = 2'b10;
    localparam logic [1:0] OP_SETCOND = 2'b11;

    localparam logic [1:0] CMD_MOVE = 2'd0;
    localparam logic [1:0] CMD_DRAW = 2'd1;
    localparam logic [1:0] CMD_CHAR = 2'd2;

    localparam logic [1:0] COND_INTENSITY = 2'b00;
    localparam logic [1:0] COND_LINE_TYPE = 2'b01;
    localparam logic [1:0] COND_CHAR_SIZE = 2'b10;
    localparam logic [1:0] COND_NONE      = 2'b11;

    localparam logic [3:0] INTENSITY_RESET = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/hp1349a_cond_regs.sv
// Set Condition register file: intensity, line type and character size,
// written one field at a time and returned to power-on defaults by reset.
module hp1349a_cond_regs
    import hp1349a_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] sel,
    input  logic [3:0] data,
    output logic [3:0] intensity,
    output logic [2:0] line_type,
    output logic [1:0] char_size
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            intensity <= INTENSITY_RESET;
            line_type <= 3'd0;
            char_size <= 2'd0;
        end else if (wr_en) begin
            case (sel)
                COND_INTENSITY: intensity <= data;
                COND_LINE_TYPE: line_type <= data[2:0];
                COND_CHAR_SIZE: char_size <= data[1:0];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hp1349a_cmd_decoder.sv
// Decodes HP1349A display words from the receive FIFO into MOVE/DRAW/CHAR
// commands for the rasteriser and tracks the Set Condition state.
module hp1349a_cmd_decoder
    import hp1349a_pkg::*;
#(
    parameter int GRAPH_STEP = 1
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_empty,
    output logic               fifo_read_en,
    input  logic [15:0]        fifo_read_data,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [1:0]         cmd_type,
    output logic [COORD_W-1:0] cmd_x,
    output logic [COORD_W-1:0] cmd_y,
    output logic [7:0]         cmd_char,
    output logic [3:0]         cond_intensity,
    output logic [2:0]         cond_line_type,
    output logic [1:0]         cond_char_size
);

    localparam logic [COORD_W-1:0] STEP = COORD_W'(GRAPH_STEP);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic [COORD_W-1:0] graph_x_q, graph_x_d;
    logic [1:0]         cmd_type_p1, cmd_type_p2;
    logic [COORD_W-1:0] cmd_x_p1, cmd_x_p2;
    logic [COORD_W-1:0] cmd_y_p1, cmd_y_p2;
    logic [7:0]         cmd_char_p1, cmd_char_p2;
    logic               cond_we;

    logic [1:0]         opcode;
    logic [COORD_W-1:0] coord;
    logic               unused_msb;

    assign opcode     = fifo_read_data[14:13];
    assign coord      = fifo_read_data[COORD_W-1:0];
    assign unused_msb = fifo_read_data[15];

    always_comb begin
        state_d      = state_q;
        fifo_read_en = 1'b0;
        cond_we      = 1'b0;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        graph_x_d    = graph_x_q;
        cmd_type_p1  = cmd_type_p2;
        cmd_x_p1     = cmd_x_p2;
        cmd_y_p1     = cmd_y_p2;
        cmd_char_p1  = cmd_char_p2;
        case (state_q)
            ST_IDLE: begin
                // Gate with rst so no word is popped on a reset edge.
                if (!fifo_empty && rst) begin
                    fifo_read_en = 1'b1;
                    state_d      = ST_FETCH;
                end
            end
            // p1: word from the FIFO is decoded into the next command.
            ST_FETCH: begin
                state_d = ST_IDLE;
                case (opcode)
                    OP_PLOT: begin
                        if (!fifo_read_data[11]) begin
                            pos_x_d   = coord;
                            graph_x_d = coord;
                        end else begin
                            pos_y_d     = coord;
                            cmd_type_p1 = fifo_read_data[12] ? CMD_DRAW : CMD_MOVE;
                            cmd_x_p1    = pos_x_q;
                            cmd_y_p1    = coord;
                            cmd_char_p1 = 8'd0;
                            state_d     = ST_EMIT;
                        end
                    end
                    OP_GRAPH: begin
                        cmd_type_p1 = CMD_DRAW;
                        cmd_x_p1    = graph_x_q;
                        cmd_y_p1    = coord;
                        cmd_char_p1 = 8'd0;
                        pos_x_d     = graph_x_q;
                        pos_y_d     = coord;
                        graph_x_d   = graph_x_q + STEP;
                        state_d     = ST_EMIT;
                    end
                    OP_TEXT: begin
                        cmd_type_p1 = CMD_CHAR;
                        cmd_x_p1    = pos_x_q;
                        cmd_y_p1    = pos_y_q;
                        cmd_char_p1 = fifo_read_data[7:0];
                        state_d     = ST_EMIT;
                    end
                    default: cond_we = 1'b1;
                endcase
            end
            ST_EMIT: begin
                if (cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // p2: registered command presented to the rasteriser.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            graph_x_q   <= '0;
            cmd_type_p2 <= CMD_MOVE;
            cmd_x_p2    <= '0;
            cmd_y_p2    <= '0;
            cmd_char_p2 <= 8'd0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            graph_x_q   <= graph_x_d;
            cmd_type_p2 <= cmd_type_p1;
            cmd_x_p2    <= cmd_x_p1;
            cmd_y_p2    <= cmd_y_p1;
            cmd_char_p2 <= cmd_char_p1;
        end
    end

    assign cmd_valid = (state_q == ST_EMIT);
    assign cmd_type  = cmd_type_p2;
    assign cmd_x     = cmd_x_p2;
    assign cmd_y     = cmd_y_p2;
    assign cmd_char  = cmd_char_p2;

    hp1349a_cond_regs u_cond_regs (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (cond_we),
        .sel       (fifo_read_data[12:11]),
        .data      (fifo_read_data[3:0]),
        .intensity (cond_intensity),
        .line_type (cond_line_type),
        .char_size (cond_char_size)
    );

endmodule

// File: tb/tb_hp1349a_cmd_decoder.sv
// Bench for hp1349a_cmd_decoder: FIFO model on the read side, collector on the
// command side, table vectors, hand-written corner sequences and random words.
module tb_hp1349a_cmd_decoder;
    import hp1349a_pkg::*;

    typedef struct {
        logic [1:0]  t;
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  c;
    } cmd_t;

    typedef struct {
        logic [15:0] w;
        bit          emit;
        logic [1:0]  t;
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  c;
        logic [3:0]  ci;
        logic [2:0]  lt;
        logic [1:0]  cs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty;
    logic        fifo_read_en;
    logic [15:0] fifo_read_data = 16'h0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_type;
    logic [10:0] cmd_x, cmd_y;
    logic [7:0]  cmd_char;
    logic [3:0]  cond_intensity;
    logic [2:0]  cond_line_type;
    logic [1:0]  cond_char_size;

    hp1349a_cmd_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_type       (cmd_type),
        .cmd_x          (cmd_x),
        .cmd_y          (cmd_y),
        .cmd_char       (cmd_char),
        .cond_intensity (cond_intensity),
        .cond_line_type (cond_line_type),
        .cond_char_size (cond_char_size)
    );

    always #5 clk = ~clk;

    logic [15:0] fifo_mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_read_en) begin
            fifo_read_data <= fifo_mem[rd_ptr % 4096];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    cmd_t got_q[$];
    cmd_t exp_q[$];
    int   strobe_q[$];
    int   rise_q[$];
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b0;
    cmd_t prev_cmd;
    vec_t tbl [14];

    int mx, my, mg, mi, ml, mcs;

    task automatic chk(input string name, input int idx, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] t, input int x, input int y, input int c);
        cmd_t r;
        r.t = t;
        r.x = 11'(x);
        r.y = 11'(y);
        r.c = 8'(c);
        return r;
    endfunction

    // One clock: sample at the falling edge, return just after the rising edge.
    task automatic step();
        cmd_t cur;
        @(negedge clk);
        cyc++;
        cur = mk(cmd_type, int'(cmd_x), int'(cmd_y), int'(cmd_char));
        if (fifo_read_en) begin
            chk("rd_en_while_empty", cyc, fifo_empty, 0);
            strobe_q.push_back(cyc);
        end
        if (cmd_valid && !prev_valid) rise_q.push_back(cyc);
        if (prev_valid && !prev_ready && prev_rst) begin
            chk("hold_valid", cyc, cmd_valid, 1);
            chk("hold_type", cyc, cur.t, prev_cmd.t);
            chk("hold_x", cyc, cur.x, prev_cmd.x);
            chk("hold_y", cyc, cur.y, prev_cmd.y);
            chk("hold_char", cyc, cur.c, prev_cmd.c);
        end
        if (cmd_valid && cmd_ready && rst) got_q.push_back(cur);
        prev_valid = cmd_valid;
        prev_ready = cmd_ready;
        prev_rst   = rst;
        prev_cmd   = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        fifo_mem[wr_ptr % 4096] = w;
        wr_ptr++;
    endtask

    task automatic wait_quiet();
        int quiet = 0;
        int budget = 0;
        while (quiet < 4 && budget < 2000) begin
            step();
            if (fifo_empty && !cmd_valid && !fifo_read_en) quiet++;
            else quiet = 0;
            budget++;
        end
        if (quiet < 4) chk("quiet_timeout", cyc, 1, 0);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!cmd_valid && k < 50) begin
            step();
            k++;
        end
        if (!cmd_valid) chk("valid_timeout", cyc, 0, 1);
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mg = 0; mi = 15; ml = 0; mcs = 0;
    endtask

    // Reference behaviour: every word updates plain integer state and appends
    // the command it should produce, independent of cycle timing.
    task automatic model(input logic [15:0] w);
        int c;
        c = int'(w[10:0]);
        case (w[14:13])
            2'b00: begin
                if (!w[11]) begin
                    mx = c;
                    mg = c;
                end else begin
                    my = c;
                    exp_q.push_back(mk(w[12] ? CMD_DRAW : CMD_MOVE, mx, my, 0));
                end
            end
            2'b01: begin
                exp_q.push_back(mk(CMD_DRAW, mg, c, 0));
                mx = mg;
                my = c;
                mg = (mg + 1) % 2048;
            end
            2'b10: exp_q.push_back(mk(CMD_CHAR, mx, my, int'(w[7:0])));
            default: begin
                if (w[12:11] == 2'b00) mi = int'(w[3:0]);
                else if (w[12:11] == 2'b01) ml = int'(w[2:0]);
                else if (w[12:11] == 2'b10) mcs = int'(w[1:0]);
            end
        endcase
    endtask

    task automatic check_got(input string tag, input int i, input cmd_t e);
        chk({tag, "_type"}, i, got_q[i].t, e.t);
        chk({tag, "_x"}, i, got_q[i].x, e.x);
        chk({tag, "_y"}, i, got_q[i].y, e.y);
        chk({tag, "_char"}, i, got_q[i].c, e.c);
    endtask

    initial begin
        tbl[0]  = '{16'h0123, 1'b0, 2'd0, 11'h000, 11'h000, 8'h00, 4'hF, 3'd0, 2'd0};
        tbl[1]  = '{16'h1A00, 1'b1, 2'd1, 11'h123, 11'h200, 8'h00, 4'hF, 3'd0, 2'd0};
        tbl[2]  = '{16'h0000, 1'b0, 2'd0, 11'h000, 11'h000, 8'h00, 4'hF, 3'd0, 2'd0};
        tbl[3]  = '{16'h0FFF, 1'b1, 2'd0, 11'h000, 11'h7FF, 8'h00, 4'hF, 3'd0, 2'd0};
        tbl[4]  = '{16'h07FF, 1'b0, 2'd0, 11'h000, 11'h000, 8'h00, 4'hF, 3'd0, 2'd0};
        tbl[5]  = '{16'h2010, 1'b1, 2'd1, 11'h7FF, 11'h010, 8'h00, 4'hF, 3'd0, 2'd0};
        tbl[6]  = '{16'h2011, 1'b1, 2'd1, 11'h000, 11'h011, 8'h00, 4'hF, 3'd0, 2'd0};
        tbl[7]  = '{16'h4041, 1'b1, 2'd2, 11'h000, 11'h011, 8'h41, 4'hF, 3'd0, 2'd0};
        tbl[8]  = '{16'h6007, 1'b0, 2'd0, 11'h000, 11'h000, 8'h00, 4'h7, 3'd0, 2'd0};
        tbl[9]  = '{16'h6805, 1'b0, 2'd0, 11'h000, 11'h000, 8'h00, 4'h7, 3'd5, 2'd0};
        tbl[10] = '{16'h7003, 1'b0, 2'd0, 11'h000, 11'h000, 8'h00, 4'h7, 3'd5, 2'd3};
        tbl[11] = '{16'h7807, 1'b0, 2'd0, 11'h000, 11'h000, 8'h00, 4'h7, 3'd5, 2'd3};
        tbl[12] = '{16'hC042, 1'b1, 2'd2, 11'h000, 11'h011, 8'h42, 4'h7, 3'd5, 2'd3};
        tbl[13] = '{16'h1805, 1'b1, 2'd1, 11'h000, 11'h005, 8'h00, 4'h7, 3'd5, 2'd3};

        rst = 1'b0;
        cmd_ready = 1'b0;
        step(); step(); step();
        chk("rst_read_en", 0, fifo_read_en, 0);
        chk("rst_valid", 0, cmd_valid, 0);
        chk("rst_type", 0, cmd_type, 0);
        chk("rst_x", 0, cmd_x, 0);
        chk("rst_y", 0, cmd_y, 0);
        chk("rst_char", 0, cmd_char, 0);
        chk("rst_intensity", 0, cond_intensity, 4'hF);
        chk("rst_line_type", 0, cond_line_type, 0);
        chk("rst_char_size", 0, cond_char_size, 0);
        rst = 1'b1;
        cmd_ready = 1'b1;

        for (int i = 0; i < 14; i++) begin
            got_q.delete();
            push(tbl[i].w);
            wait_quiet();
            chk("tbl_count", i, got_q.size(), tbl[i].emit ? 1 : 0);
            if (tbl[i].emit && got_q.size() >= 1)
                check_got("tbl", 0, mk(tbl[i].t, int'(tbl[i].x), int'(tbl[i].y), int'(tbl[i].c)));
            chk("tbl_intensity", i, cond_intensity, tbl[i].ci);
            chk("tbl_line_type", i, cond_line_type, tbl[i].lt);
            chk("tbl_char_size", i, cond_char_size, tbl[i].cs);
        end

        // Backpressure: CHAR held for 5 cycles, next word must not be read.
        got_q.delete();
        cmd_ready = 1'b0;
        push(16'h4041);
        push(16'h0333);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_read_en", k, fifo_read_en, 0);
            chk("bp_valid", k, cmd_valid, 1);
            chk("bp_char", k, cmd_char, 8'h41);
        end
        cmd_ready = 1'b1;
        wait_quiet();
        chk("bp_count", 0, got_q.size(), 1);
        if (got_q.size() >= 1) check_got("bp", 0, mk(CMD_CHAR, 0, 5, 8'h41));

        // Reset while a DRAW is waiting for the rasteriser.
        got_q.delete();
        cmd_ready = 1'b0;
        push(16'h0100);
        push(16'h1A00);
        wait_valid();
        rst = 1'b0;
        step();
        chk("rstemit_valid", 0, cmd_valid, 0);
        chk("rstemit_intensity", 0, cond_intensity, 4'hF);
        chk("rstemit_line_type", 0, cond_line_type, 0);
        rst = 1'b1;
        cmd_ready = 1'b1;
        push(16'h1A22);
        wait_quiet();
        chk("rstemit_count", 0, got_q.size(), 1);
        if (got_q.size() >= 1) check_got("rstemit", 0, mk(CMD_DRAW, 0, 12'h222, 0));

        // Latency of back-to-back emitting and non-emitting words.
        strobe_q.delete();
        rise_q.delete();
        push(16'h1A00);
        push(16'h1A01);
        wait_quiet();
        chk("lat_strobes", 0, strobe_q.size(), 2);
        chk("lat_rises", 0, rise_q.size(), 2);
        if (strobe_q.size() == 2 && rise_q.size() == 2) begin
            chk("lat_valid_after_strobe", 0, rise_q[0] - strobe_q[0], 2);
            chk("lat_strobe_gap_emit", 0, strobe_q[1] - strobe_q[0], 3);
            chk("lat_valid_after_strobe", 1, rise_q[1] - strobe_q[1], 2);
        end
        strobe_q.delete();
        push(16'h0001);
        push(16'h0002);
        wait_quiet();
        chk("lat_strobes_noemit", 0, strobe_q.size(), 2);
        if (strobe_q.size() == 2)
            chk("lat_strobe_gap_noemit", 0, strobe_q[1] - strobe_q[0], 2);

        // Random words with random backpressure against the reference model.
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        model_reset();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            logic [15:0] w;
            cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                w = 16'($urandom);
                push(w);
                model(w);
            end
            step();
        end
        cmd_ready = 1'b1;
        wait_quiet();
        chk("rnd_count", 0, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_got("rnd", i, exp_q[i]);
        chk("rnd_intensity", 0, cond_intensity, mi);
        chk("rnd_line_type", 0, cond_line_type, ml);
        chk("rnd_char_size", 0, cond_char_size, mcs);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hp1349a_cmd_decoder.md
# hp1349a_cmd_decoder

Consumes the 16-bit word FIFO filled by the HP1349A bus receiver and decodes each 15-bit HP1349A display word into drawing commands for the vector rasteriser. It pairs Plot X/Y words into absolute move/draw vectors, expands Graph words with an auto-incrementing X position, and passes Text characters through. It also holds the Set Condition state (intensity, line type, character size) as static outputs. It sits between the bus-receive FIFO read port and the rasteriser command input.

## Interface
- GRAPH_STEP, 1: X increment (11-bit, modulo 2048) applied after each Graph word.
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  reset; synchronous and active-low (all state cleared on a clk edge with rst=0).
- fifo_empty  input  1  FIFO has no word.
- fifo_read_en  output  1  one-cycle read strobe.
- fifo_read_data  input  16  word, valid the cycle after fifo_read_en; bit 15 ignored.
- cmd_valid  output  1  command presented.
- cmd_ready  input  1  rasteriser accepts the command when cmd_valid&cmd_ready.
- cmd_type  output  2  0=MOVE, 1=DRAW, 2=CHAR.
- cmd_x, cmd_y  output  11 each  target / character position.
- cmd_char  output  8  character code (CHAR only, else 0).
- cond_intensity  output  4  current intensity.
- cond_line_type  output  3  current line type.
- cond_char_size  output  2  current character size.

## Operation
- Word decode on bits 14:13: 00 Plot, 01 Graph, 10 Text, 11 Set Condition.
- Plot: bit 11=0 is an X word; it latches pos_x<=bits10:0 and emits nothing. Bit 11=1 is a Y word; it latches pos_y and emits DRAW if bit 12=1, else MOVE, at (pos_x, new y).
- Graph: emits DRAW to (graph_x, bits10:0). After the emit, pos_x<=graph_x, pos_y<=y, and graph_x<=graph_x+GRAPH_STEP (wraps 2047->0). A Plot X word also loads graph_x.
- Text: emits CHAR with cmd_char=bits7:0 at (pos_x,pos_y). Position is unchanged (character advance belongs to the rasteriser).
- Set Condition: bits12:11 select the field. 00 sets intensity=bits3:0, 01 sets line_type=bits2:0, 10 sets char_size=bits1:0, 11 is ignored. Nothing is emitted; the new value is visible on the next cycle.
- FSM states and transitions:
  - IDLE: if !fifo_empty, pulse fifo_read_en and go to FETCH.
  - FETCH: decode fifo_read_data. Go to EMIT if the word emits, else to IDLE.
  - EMIT: hold cmd_* stable with cmd_valid=1 until cmd_ready, then go to IDLE.
- No new FIFO read is issued while in FETCH or EMIT. fifo_read_en is never asserted when fifo_empty=1.

## Timing
- Reset values:
  - fifo_read_en=0, cmd_valid=0, cmd_type=0, cmd_x=cmd_y=0, cmd_char=0.
  - pos_x=pos_y=graph_x=0.
  - cond_intensity=4'hF, cond_line_type=0, cond_char_size=0.
  - FSM in IDLE.
- Latency: read strobe at cycle N, decode at N+1, cmd_valid at N+2 (registered). With cmd_ready held high, the handshake completes at N+2 and the next strobe is at N+3. Emitting words therefore take 3 cycles each; non-emitting words take 2.
- cmd_ready high while cmd_valid=0 has no effect.
- cmd_* are stable while cmd_valid=1 && !cmd_ready.
- Reset asserted mid-EMIT drops cmd_valid on that edge and loses the word.

## Structure
- Package hp1349a_pkg holds:
  - opcode constants (OP_PLOT, OP_GRAPH, OP_TEXT, OP_SETCOND);
  - cmd_type constants (CMD_MOVE, CMD_DRAW, CMD_CHAR);
  - condition field selectors;
  - the coordinate width (11).
- One natural sub-module, hp1349a_cond_regs: the Set Condition register file, with write enable, field select, data, and reset to defaults.

## Test plan
- Plot pair: push 0x0123 (X=0x123) then 0x1A00 (Y=0x200, pen=1) -> one DRAW at (0x123,0x200); no output after the X word alone.
- Move: push X 0x0000, Y 0x0FFF (bit12=0, Y=0x7FF) -> MOVE at (0,0x7FF).
- Graph wrap: push X 0x07FF, then Graph 0x2010 and 0x2011 -> DRAW (0x7FF,0x010), then DRAW (0x000,0x011).
- Backpressure: Text 0x4041 with cmd_ready low for 5 cycles -> CHAR 0x41 held stable; fifo_read_en stays 0 until the handshake completes.
- Set Condition: push 0x6007 (intensity 7) and 0x6805 (line type 5) -> cond_intensity=7 and cond_line_type=5; no cmd_valid.
- Reset in EMIT: assert rst=0 while cmd_valid=1 -> next cycle cmd_valid=0, cond_intensity=0xF, pos=0; the following Plot Y draws from X=0.
